// File: rtl/readback_hub_pkg.sv
// rtl/readback_hub_pkg.sv - readback word layout and channel map shared by the hub and its users
package readback_hub_pkg;
  localparam int CTRL_W    = 4;
  localparam int PAYLOAD_W = 24;
  localparam int RB_WORD_W = CTRL_W + PAYLOAD_W;
  localparam int MAX_CH    = 15;

  // Channel slots in the core-side module map
  localparam int CH_SONAR  = 0;
  localparam int CH_RC     = 1;
  localparam int CH_IMU    = 2;
  localparam int CH_ODOM   = 3;
  localparam int CH_POWER  = 4;
  localparam int CH_STATUS = 5;
endpackage

// File: rtl/readback_hub_fifo.sv
// rtl/readback_hub_fifo.sv - per-channel word FIFO; full/empty come from the registered occupancy count
module rb_chan_fifo #(
  parameter int DATA_W     = 28,
  parameter int FIFO_DEPTH = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              push,
  input  logic [DATA_W-1:0] push_data,
  input  logic              pop,
  output logic [DATA_W-1:0] head,
  output logic              full,
  output logic              empty
);
  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [DATA_W-1:0] mem_q [FIFO_DEPTH];
  logic [PTR_W-1:0]  wr_ptr_q, rd_ptr_q;
  logic [CNT_W-1:0]  count_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      unique case ({push, pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= push_data;
  end

  assign head  = mem_q[rd_ptr_q];
  assign full  = (count_q == CNT_W'(FIFO_DEPTH));
  assign empty = (count_q == '0);
endmodule

// File: rtl/readback_hub.sv
// rtl/readback_hub.sv - merges per-channel readback FIFOs into one tagged valid/ready stream
module readback_hub
  import readback_hub_pkg::*;
#(
  parameter int              N_CH        = 6,
  parameter int              DATA_W      = RB_WORD_W,
  parameter int              FIFO_DEPTH  = 4,
  parameter int              ADDR_W      = 4,
  parameter logic [N_CH-1:0] URGENT_MASK = '0
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [N_CH*DATA_W-1:0] in_data,
  input  logic [N_CH-1:0]        in_wr,
  output logic [N_CH-1:0]        in_busy,
  output logic [DATA_W-1:0]      out_data,
  output logic [ADDR_W-1:0]      out_addr,
  output logic                   out_valid,
  input  logic                   out_rdy,
  output logic                   out_urgent,
  output logic [N_CH-1:0]        ovf,
  input  logic [N_CH-1:0]        ovf_clr
);
  if (N_CH < 1 || N_CH > MAX_CH || N_CH > (1 << ADDR_W) - 1) begin : g_bad_cfg
    $error("readback_hub: N_CH does not fit the out_addr tag");
  end

  logic [N_CH-1:0]             full, empty, nonempty, push, pop, urg_ne, cand;
  logic [N_CH-1:0][DATA_W-1:0] head;

  for (genvar gi = 0; gi < N_CH; gi++) begin : g_ch
    rb_chan_fifo #(.DATA_W(DATA_W), .FIFO_DEPTH(FIFO_DEPTH)) u_fifo (
      .clk       (clk),
      .rst       (rst),
      .push      (push[gi]),
      .push_data (in_data[gi*DATA_W +: DATA_W]),
      .pop       (pop[gi]),
      .head      (head[gi]),
      .full      (full[gi]),
      .empty     (empty[gi])
    );
  end

  assign nonempty = ~empty;
  assign push     = in_wr & ~full;
  assign in_busy  = full;

  logic              out_valid_q;
  logic [DATA_W-1:0] out_data_q;
  logic [ADDR_W-1:0] out_addr_q, rr_ptr_q, rr_ptr_d;
  logic [N_CH-1:0]   ovf_q, ovf_d;

  logic              load, gnt_valid, hi_found, cur_urgent;
  logic [ADDR_W-1:0] hi_idx, lo_idx, gnt_idx;
  logic [DATA_W-1:0] gnt_data;

  // Urgent channels narrow the candidate set; the same rr_ptr then rotates within it
  always_comb begin
    load      = ~out_valid_q | out_rdy;
    urg_ne    = nonempty & URGENT_MASK;
    cand      = (|urg_ne) ? urg_ne : nonempty;
    gnt_valid = |cand;
    hi_found  = 1'b0;
    hi_idx    = '0;
    lo_idx    = '0;
    for (int j = N_CH - 1; j >= 0; j--) begin
      if (cand[j]) begin
        lo_idx = ADDR_W'(j);
        if (ADDR_W'(j) >= rr_ptr_q) begin
          hi_found = 1'b1;
          hi_idx   = ADDR_W'(j);
        end
      end
    end
    gnt_idx    = hi_found ? hi_idx : lo_idx;
    gnt_data   = '0;
    pop        = '0;
    cur_urgent = 1'b0;
    for (int j = 0; j < N_CH; j++) begin
      if (gnt_idx == ADDR_W'(j)) begin
        gnt_data = head[j];
        pop[j]   = load & gnt_valid;
      end
      if (out_addr_q == ADDR_W'(j)) cur_urgent = URGENT_MASK[j];
    end
    rr_ptr_d = (gnt_idx == ADDR_W'(N_CH - 1)) ? '0 : gnt_idx + 1'b1;
    ovf_d    = (ovf_q & ~ovf_clr) | (in_wr & full);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_addr_q  <= '0;
      rr_ptr_q    <= '0;
      ovf_q       <= '0;
    end else begin
      ovf_q <= ovf_d;
      if (load) begin
        out_valid_q <= gnt_valid;
        if (gnt_valid) begin
          out_data_q <= gnt_data;
          out_addr_q <= gnt_idx;
          rr_ptr_q   <= rr_ptr_d;
        end
      end
    end
  end

  assign out_valid  = out_valid_q;
  assign out_data   = out_data_q;
  assign out_addr   = out_addr_q;
  assign ovf        = ovf_q;
  assign out_urgent = (out_valid_q & cur_urgent) | (|urg_ne);
endmodule
